seg_dynamic_drv: RTL
====================

Name: seg_dynamic_drv

Overview:
Display-side consumer of the meter's price/point/seg_en/sign bundle. It converts the 20-bit binary price to BCD sequentially and drives a 6-digit common-anode seven-segment display by time-multiplexed scanning. It provides leading-zero blanking, decimal points and a minus sign. It sits between the fare-computation block and the board's digit-select and segment pins.

Parameters:
CNT_MAX, 16'd49_999, per-digit dwell count minus 1 (1 ms at 50 MHz); benches use 9.
NUM_DIG, 6, digit count; fixed at 6 in this revision.

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst_n  in  1  asynchronous, active-low reset
data  in  20  unsigned value to display
point  in  6  decimal-point enables, bit i = digit i, high = lit
seg_en  in  1  display enable, high = on
sign  in  1  high = show minus sign
sel  out  6  digit select, active-low, one-hot; bit 0 = rightmost digit
seg  out  8  segments, active-low; [6:0] = g..a, [7] = dp

Behaviour:
- Reset, asynchronous on sys_rst_n low:
  - sel=6'h3F, seg=8'hFF.
  - bcd register=0, digit index=0, dwell counter=0, converter in IDLE.
- Clamp before conversion:
  - sign=0: value = min(data, 999_999).
  - sign=1: value = min(data, 99_999), so one digit is left free for '-'.
- Converter FSM (IDLE -> SHIFT -> DONE -> IDLE):
  - IDLE: when the clamped value differs from last_val, or on the first cycle after reset, capture the value into a 20-bit shift register and clear a 24-bit BCD accumulator. Go to SHIFT.
  - SHIFT: 20 cycles of double-dabble. Add 3 to each BCD nibble >=5, then shift left 1 with the binary MSB entering the BCD LSB.
  - DONE: copy the accumulator to the bcd register and the captured value to last_val, both in the same cycle. Return to IDLE.
  - Latency from data change to new bcd <= 23 cycles.
  - If data changes during SHIFT, the current conversion completes with the old value; the next IDLE sees the mismatch and restarts. The bcd register never holds a partial result.
- Scan timing:
  - Dwell counter counts 0..CNT_MAX, then wraps.
  - On wrap, the digit index advances 0->1->...->5->0.
  - Each digit is lit for CNT_MAX+1 cycles; a full frame is 6*(CNT_MAX+1) cycles.
- Digit content for index i, with d_i = BCD nibble i:
  - Highest significant digit h = highest i with d_i != 0, or with point[i]=1; h = 0 when all are zero.
  - i <= h: show the code for d_i.
  - i == h+1 and sign=1: show '-' (8'hBF).
  - Otherwise: blank (8'hFF).
  - Digit 0 is always shown, so value 0 displays "0".
  - dp: seg[7]=~point[i], applied to blank digits as well.
- Segment codes, active-low, before dp:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - minus=BF, blank=FF.
- Outputs are registered; sel and seg change in the same cycle, one cycle after the index changes.
- seg_en=0: sel=6'h3F and seg=8'hFF from the next cycle. Scan and conversion keep running, so re-enable shows current data with no restart.
- point and sign are sampled live each cycle, not through the converter.
- Reset mid-scan or mid-conversion: immediate return to the reset values above, with a fresh conversion after release.

Decomposition:
- Package seg_pkg holds:
  - NUM_DIG.
  - The 10 digit codes as a constant array, plus SEG_MINUS and SEG_BLANK.
  - The converter state encoding (IDLE/SHIFT/DONE).
- Sub-module bin2bcd_seq (clk, rst_n, bin[19:0], bcd[23:0], busy) implements the converter FSM. The top level handles the clamp, scan, blanking and sign.

Test Plan (CNT_MAX=9):
- Reset release with data=0, seg_en=1 -> within 23 cycles, digit 0 shows C0 and digits 1..5 show FF. The sel sequence is 3E,3D,3B,37,2F,1F, changing every 10 cycles.
- data=123_456, point=6'b000100 -> digits 5..0 show F9,A4,B0,99,92,82, with seg[7]=0 only on digit 2 (code 19).
- data=8, sign=1 -> digit 0 shows 80, digit 1 shows BF, digits 2..5 show FF. Then data=1_048_575 with sign=1 clamps to 99_999: digits 0..4 show 90 and digit 5 shows BF.
- data changes 8 -> 20 during SHIFT -> bcd first settles to 8, then to 20 within a further 23 cycles. Digit 0 never shows anything other than 80 or C0.
- seg_en toggled 1->0->1 mid-frame -> sel=3F and seg=FF on the next cycle. On re-enable, the scan index continues with no discontinuity.
- Assert sys_rst_n=0 during SHIFT -> sel=3F and seg=FF immediately (asynchronously). After release, the display reconverts and shows the current data.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and types for the seven-segment display driver
package seg_pkg;

    localparam int NUM_DIG = 6;

    // Active-low codes with dp off; index is the decimal digit value.
    localparam logic [9:0][7:0] SEG_DIGIT = {
        8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
        8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };
    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        CONV_IDLE  = 2'd0,
        CONV_SHIFT = 2'd1,
        CONV_DONE  = 2'd2
    } conv_state_e;

    function automatic logic [7:0] digit_code(input logic [3:0] d);
        if (d > 4'd9) begin
            return SEG_BLANK;
        end
        return SEG_DIGIT[d];
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential 20-bit binary to 6-digit BCD converter (double-dabble)
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] bin,
    output logic [23:0] bcd,
    output logic        busy
);

    conv_state_e state_q, state_d;
    logic [19:0] shift_q, shift_d;
    logic [19:0] cap_q, cap_d;
    logic [19:0] last_val_q, last_val_d;
    logic [23:0] acc_q, acc_d;
    logic [23:0] bcd_q, bcd_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        first_q, first_d;
    logic [23:0] adj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CONV_IDLE;
            shift_q    <= '0;
            cap_q      <= '0;
            last_val_q <= '0;
            acc_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            first_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cap_q      <= cap_d;
            last_val_q <= last_val_d;
            acc_q      <= acc_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
        end
    end

    always_comb begin
        adj = acc_q;
        for (int n = 0; n < NUM_DIG; n++) begin
            if (acc_q[n*4 +: 4] >= 4'd5) begin
                adj[n*4 +: 4] = acc_q[n*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cap_d      = cap_q;
        last_val_d = last_val_q;
        acc_d      = acc_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        first_d    = first_q;
        unique case (state_q)
            CONV_IDLE: begin
                if (first_q || (bin != last_val_q)) begin
                    shift_d = bin;
                    cap_d   = bin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    first_d = 1'b0;
                    state_d = CONV_SHIFT;
                end
            end
            CONV_SHIFT: begin
                acc_d   = {adj[22:0], shift_q[19]};
                shift_d = {shift_q[18:0], 1'b0};
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'd19) begin
                    state_d = CONV_DONE;
                end
            end
            CONV_DONE: begin
                // Result and its source value are published together so
                // the mismatch test in IDLE always compares a finished pair.
                bcd_d      = acc_q;
                last_val_d = cap_q;
                state_d    = CONV_IDLE;
            end
            default: state_d = CONV_IDLE;
        endcase
    end

    assign bcd  = bcd_q;
    assign busy = (state_q != CONV_IDLE);

endmodule

// File: rtl/seg_dynamic_drv.sv
// rtl/seg_dynamic_drv.sv - 6-digit multiplexed seven-segment driver with blanking, dp and sign
module seg_dynamic_drv
    import seg_pkg::*;
#(
    parameter logic [15:0] CNT_MAX = 16'd49_999
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [19:0] data,
    input  logic [5:0]  point,
    input  logic        seg_en,
    input  logic        sign,
    output logic [5:0]  sel,
    output logic [7:0]  seg
);

    localparam logic [19:0] MAX_POS = 20'd999_999;
    localparam logic [19:0] MAX_NEG = 20'd99_999;

    logic [19:0] lim;
    logic [19:0] val;
    logic [23:0] bcd;
    logic        conv_busy_unused;

    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [5:0]  sel_q, sel_d;
    logic [7:0]  seg_q, seg_d;
    logic [2:0]  hi;
    logic [3:0]  nib;
    logic [7:0]  code;

    // A negative value gives up the top digit to the minus sign.
    assign lim = sign ? MAX_NEG : MAX_POS;
    assign val = (data > lim) ? lim : data;

    bin2bcd_seq u_conv (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .bin   (val),
        .bcd   (bcd),
        .busy  (conv_busy_unused)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
            sel_q <= 6'h3F;
            seg_q <= SEG_BLANK;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            sel_q <= sel_d;
            seg_q <= seg_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        idx_d = idx_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = (idx_q == 3'(NUM_DIG - 1)) ? 3'd0 : idx_q + 3'd1;
        end
    end

    // A lit decimal point forces its digit (and any zeros below it) visible.
    always_comb begin
        hi  = '0;
        nib = '0;
        for (int i = 0; i < NUM_DIG; i++) begin
            if ((bcd[i*4 +: 4] != 4'd0) || point[i]) begin
                hi = 3'(i);
            end
            if (3'(i) == idx_q) begin
                nib = bcd[i*4 +: 4];
            end
        end
    end

    always_comb begin
        code = SEG_BLANK;
        if (idx_q <= hi) begin
            code = digit_code(nib);
        end else if (sign && (idx_q == hi + 3'd1)) begin
            code = SEG_MINUS;
        end
        code[7] = ~point[idx_q];

        sel_d = 6'h3F;
        seg_d = SEG_BLANK;
        if (seg_en) begin
            sel_d = ~(6'b000001 << idx_q);
            seg_d = code;
        end
    end

    assign sel = sel_q;
    assign seg = seg_q;

endmodule
